// File: rtl/vanilla_sb_stall_profiler.sv
// Scoreboard stall profiler: attributes dependency stalls to a cause and dumps counters.
// Define VANILLA_SB_PROFILER_FLOAT_EN to add the five float-scoreboard categories.
module vanilla_sb_stall_profiler #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [2**reg_addr_width_p-1:0][6:0]    int_sb_i,
  input  logic [2**reg_addr_width_p-1:0][4:0]    float_sb_i,
  input  logic                                   stall_depend_i,
  input  logic                                   stall_all_i,
  input  logic [reg_addr_width_p-1:0]            rs1_i,
  input  logic [reg_addr_width_p-1:0]            rs2_i,
  input  logic [reg_addr_width_p-1:0]            rs3_i,
  input  logic                                   rs1_fp_i,
  input  logic                                   rs2_fp_i,
  input  logic                                   rs3_fp_i,
  input  logic [2:0]                             rs_v_i,
  input  logic                                   dump_req_i,
  output logic                                   dump_v_o,
  input  logic                                   dump_ready_i,
  output logic [3:0]                             dump_idx_o,
  output logic [data_width_p-1:0]                dump_data_o,
  output logic                                   dump_last_o,
  output logic [data_width_p-1:0]                streak_max_o
);

`ifdef VANILLA_SB_PROFILER_FLOAT_EN
  localparam int num_cnt_lp = 13;
`else
  localparam int num_cnt_lp = 8;
`endif
  localparam int cw_lp = $clog2(num_cnt_lp);
  localparam logic [cw_lp-1:0] other_lp = cw_lp'(num_cnt_lp - 1);
  localparam logic [data_width_p-1:0] one_lp = data_width_p'(1);

  typedef enum logic {
    IDLE,
    DUMP
  } state_t;

  state_t state_q, state_n;
  logic [cw_lp-1:0] idx_q, idx_n;
  logic [cw_lp-1:0] sel;
  logic [data_width_p-1:0] cnt_q [num_cnt_lp];
  logic [data_width_p-1:0] run_q, run_inc, streak_q;
  logic [reg_addr_width_p-1:0] rs [3];
  logic [2:0] fp;
  logic [6:0] isb;
  logic counted;

  assign rs[0] = rs1_i;
  assign rs[1] = rs2_i;
  assign rs[2] = rs3_i;
  assign fp = {rs3_fp_i, rs2_fp_i, rs1_fp_i};
  assign counted = stall_depend_i & ~stall_all_i;

`ifdef VANILLA_SB_PROFILER_FLOAT_EN
  logic [4:0] fsb;

  always_comb begin
    isb = '0;
    fsb = '0;
    for (int s = 0; s < 3; s++) begin
      if (rs_v_i[s]) begin
        if (fp[s]) fsb = fsb | float_sb_i[rs[s]];
        else isb = isb | int_sb_i[rs[s]];
      end
    end
  end

  // Scan lowest priority first so the highest-priority hit wins.
  always_comb begin
    sel = other_lp;
    for (int k = 4; k >= 0; k--) begin
      if (fsb[k]) sel = cw_lp'(7 + k);
    end
    for (int k = 6; k >= 0; k--) begin
      if (isb[k]) sel = cw_lp'(k);
    end
  end
`else
  logic unused_float;
  assign unused_float = ^float_sb_i;

  // Float-selected sources never contribute in this build.
  always_comb begin
    isb = '0;
    for (int s = 0; s < 3; s++) begin
      if (rs_v_i[s] && !fp[s]) isb = isb | int_sb_i[rs[s]];
    end
  end

  always_comb begin
    sel = other_lp;
    for (int k = 6; k >= 0; k--) begin
      if (isb[k]) sel = cw_lp'(k);
    end
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_cnt_lp; k++) cnt_q[k] <= '0;
    end else if (counted) begin
      if (cnt_q[sel] != '1) cnt_q[sel] <= cnt_q[sel] + one_lp;
    end
  end

  assign run_inc = (run_q == '1) ? run_q : run_q + one_lp;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      run_q    <= '0;
      streak_q <= '0;
    end else if (counted) begin
      run_q <= run_inc;
      if (run_inc > streak_q) streak_q <= run_inc;
    end else begin
      run_q <= '0;
    end
  end

  assign streak_max_o = streak_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    dump_v_o    = 1'b0;
    dump_last_o = 1'b0;
    dump_data_o = '0;
    unique case (state_q)
      IDLE: begin
        if (dump_req_i) begin
          state_n = DUMP;
          idx_n   = '0;
        end
      end
      DUMP: begin
        dump_v_o    = 1'b1;
        dump_last_o = (idx_q == other_lp);
        dump_data_o = cnt_q[idx_q];
        if (dump_ready_i) begin
          if (idx_q == other_lp) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + cw_lp'(1);
          end
        end
      end
    endcase
  end

  assign dump_idx_o = 4'(idx_q);

endmodule

// File: doc/vanilla_sb_stall_profiler.md
VANILLA_SB_STALL_PROFILER -- requirements
Module: vanilla_sb_stall_profiler

Interface
REQ-001 SHALL have parameter `data_width_p`, default 32: width of each stall counter and of `dump_data_o`.
REQ-002 SHALL have parameter `reg_addr_width_p`, default 5: register index width; the register file has 2**`reg_addr_width_p` entries.
REQ-003 SHALL have port `clk_i`  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port `reset_i`  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port `int_sb_i`  in  2**`reg_addr_width_p` x 7: per-register integer scoreboard bits, in this order: idiv, remote_dram_load, remote_amo_dram, remote_dmem_overflow_load, remote_global_load, remote_group_load, remote_amo_group.
REQ-006 SHALL have port `float_sb_i`  in  2**`reg_addr_width_p` x 5: per-register float scoreboard bits, in this order: fdiv_fsqrt, remote_dram_load, remote_global_load, remote_group_load, remote_dmem_overflow_load.
REQ-007 SHALL have port `stall_depend_i`  in  1: the ID stage is stalled on a dependency this cycle.
REQ-008 SHALL have port `stall_all_i`  in  1: global pipeline stall; while high, no counter increments.
REQ-009 SHALL have ports `rs1_i`, `rs2_i`, `rs3_i`  in  `reg_addr_width_p` each: source register indices of the instruction in ID.
REQ-010 SHALL have ports `rs1_fp_i`, `rs2_fp_i`, `rs3_fp_i`, `rs_v_i`  in  1,1,1,3: per source, float-file select; `rs_v_i` bit k marks source k+1 as read by the instruction.
REQ-011 SHALL have port `dump_req_i`  in  1: single-cycle request to dump all counters.
REQ-012 SHALL have ports `dump_v_o`/`dump_ready_i`  out/in  1/1: valid/ready pair for the dump stream.
REQ-013 SHALL have ports `dump_idx_o`  out  4, `dump_data_o`  out  `data_width_p`, `dump_last_o`  out  1.
REQ-014 SHALL have port `streak_max_o`  out  `data_width_p`: longest run of consecutive counted stall cycles since reset.

Function
REQ-015 SHALL treat a cycle as counted when `stall_depend_i` & ~`stall_all_i`.
REQ-016 SHALL, for each counted cycle, OR the scoreboard bits of every valid source (indexed in the int or float file according to its fp select) and increment exactly one counter, chosen by fixed priority: int categories 0-6 in REQ-005 order, then float categories 7-11 in REQ-006 order, then index 12, "other", when no bit is set.
REQ-017 SHALL make the counters saturating: a counter at all-ones stays at all-ones.
REQ-018 SHALL implement a state machine IDLE -> DUMP -> IDLE: `dump_req_i` in IDLE moves to DUMP with the index at 0; `dump_req_i` in DUMP is ignored.
REQ-019 SHALL, in DUMP, hold `dump_v_o`=1, `dump_idx_o`=index and `dump_data_o`=the live counter value; the index advances only when `dump_v_o` & `dump_ready_i`.
REQ-020 SHALL assert `dump_last_o` with the highest index, and SHALL return to IDLE on acceptance of that beat; counters are not cleared by a dump.
REQ-021 SHALL, when an increment and an acceptance hit the same counter in the same cycle, emit the pre-increment value; the increment still takes effect.
REQ-022 SHALL keep a run counter that increments on counted cycles and clears on any non-counted cycle; `streak_max_o` updates to run+1 whenever run+1 exceeds it, in the same edge; the run counter saturates.

Reset
REQ-023 SHALL, on `reset_i` high, immediately clear all counters, the run counter and `streak_max_o`, enter IDLE, and drive `dump_v_o`=0, `dump_idx_o`=0, `dump_data_o`=0, `dump_last_o`=0.
REQ-024 SHALL, on reset asserted mid-dump, abandon the dump with no further beats.

Configuration
REQ-025 SHALL, with `VANILLA_SB_PROFILER_FLOAT_EN` defined, implement 13 counters (indices 0-12) as in REQ-016.
REQ-026 SHALL, without `VANILLA_SB_PROFILER_FLOAT_EN`, ignore `float_sb_i`, treat fp-selected sources as never set, implement 8 counters with "other" at index 7, and end the dump at index 7.

Verification
REQ-027 SHALL cover: `int_sb_i`[3].remote_dram_load=1, rs1=3 valid, `stall_depend_i` high for 5 cycles -> then dump gives counter 1 = 5, all others 0, `streak_max_o`=5.
REQ-028 SHALL cover: idiv and float group bits both set on valid sources for 1 counted cycle -> only counter 0 increments; with no bits set -> counter 12 increments.
REQ-029 SHALL cover: `stall_depend_i`=1 and `stall_all_i`=1 for 10 cycles -> no counter changes, and the run counter resets.
REQ-030 SHALL cover: dump with `dump_ready_i` toggling 1,0,1... -> 13 beats, indices 0..12 in order, `dump_last_o` only on index 12, held stable while stalled.
REQ-031 SHALL cover: a counter preset to all-ones plus 3 more counted cycles -> it reads all-ones.
REQ-032 SHALL cover: reset asserted at dump beat 4 -> `dump_v_o` drops asynchronously, and after release all counters read 0.
